// File: rtl/tx_encode_66b.sv
// 64b/66b transmit encoder: classify XGMII word, run the TX state machine, emit a 66-bit block.
// Build option ENC_ERRCNT_EN enables the saturating errd_blks counter (tied to zero otherwise).
module tx_encode_66b #(
    parameter int ERRCNT_W = 8
) (
    input  logic                clk156,
    input  logic                rst156,
    input  logic [63:0]         txdata,
    input  logic [7:0]          txcontrol,
    input  logic                clear_errblk,
    output logic [65:0]         TXD_Encoded,
    output logic [2:0]          tx_type,
    output logic [ERRCNT_W-1:0] errd_blks
);

    typedef enum logic [2:0] {CLS_C = 3'd0, CLS_S = 3'd1, CLS_T = 3'd2, CLS_D = 3'd3, CLS_E = 3'd4} blk_cls_t;
    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;

    localparam logic [63:0] IDLE_WORD = {8{8'h07}};
    localparam logic [65:0] EBLOCK_T  = {{8{7'h1E}}, 8'h1E, 2'b01};
    localparam logic [65:0] LBLOCK_T  = {28'h0, 4'h0, 8'h01, 8'h00, 8'h00, 8'h4B, 2'b01};
    // Terminate block type bytes, indexed by the lane holding /T/
    localparam logic [63:0] TTYPES    = 64'hFF_E1_D2_CC_B4_AA_99_87;

    logic [63:0]      r_txd;
    logic [7:0]       r_txc;
    tx_state_t        r_state;

    logic [7:0]       w_isI, w_isE, w_isT, w_vld, w_tk;
    logic [7:0][6:0]  w_code;
    logic             w_isS0, w_isS4, w_isO0;
    logic             w_d, w_s0, w_s4, w_t, w_call, w_os;
    logic [55:0]      w_tpay;
    logic [7:0]       w_ttype;
    logic [65:0]      w_blk;
    blk_cls_t         w_cls;
    tx_state_t        w_nxt;

    // Stage 1: register the word; reset loads an all-idle word
    always_ff @(posedge clk156) begin
        if (rst156) begin
            r_txd <= IDLE_WORD;
            r_txc <= 8'hFF;
        end else begin
            r_txd <= txdata;
            r_txc <= txcontrol;
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_isI[k]  = r_txc[k] && (r_txd[8*k +: 8] == 8'h07);
            w_isE[k]  = r_txc[k] && (r_txd[8*k +: 8] == 8'hFE);
            w_isT[k]  = r_txc[k] && (r_txd[8*k +: 8] == 8'hFD);
            w_vld[k]  = w_isI[k] | w_isE[k];
            w_code[k] = w_isE[k] ? 7'h1E : 7'h00;
        end
    end

    assign w_isS0 = r_txc[0] && (r_txd[7:0]   == 8'hFB);
    assign w_isS4 = r_txc[4] && (r_txd[39:32] == 8'hFB);
    assign w_isO0 = r_txc[0] && (r_txd[7:0]   == 8'h9C);

    // Terminate: data below /T/, idle/error above; code Cj always lands at bit 7*j
    always_comb begin
        w_tk    = '0;
        w_tpay  = '0;
        w_ttype = TTYPES[7:0];
        for (int k = 0; k < 8; k++) begin
            w_tk[k] = w_isT[k];
            for (int j = 0; j < 8; j++) begin
                if (j < k)      w_tk[k] = w_tk[k] & ~r_txc[j];
                else if (j > k) w_tk[k] = w_tk[k] & w_vld[j];
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (w_tk[k]) begin
                w_ttype = TTYPES[8*k +: 8];
                for (int j = 0; j < 8; j++) begin
                    if (j < k)      w_tpay[8*j +: 8] = r_txd[8*j +: 8];
                    else if (j > k) w_tpay[7*j +: 7] = w_code[j];
                end
            end
        end
    end

    assign w_d    = (r_txc == 8'h00);
    assign w_s0   = w_isS0 && (r_txc[7:1] == 7'h00);
    assign w_s4   = (&w_vld[3:0]) && w_isS4 && (r_txc[7:5] == 3'b000);
    assign w_t    = |w_tk;
    assign w_call = &w_vld;
    assign w_os   = w_isO0 && (r_txc[3:1] == 3'b000) && (&w_isI[7:4]);

    always_comb begin
        w_cls = CLS_E;
        w_blk = EBLOCK_T;
        if (w_d) begin
            w_cls = CLS_D;
            w_blk = {r_txd, 2'b10};
        end else if (w_s0) begin
            w_cls = CLS_S;
            w_blk = {r_txd[63:8], 8'h78, 2'b01};
        end else if (w_s4) begin
            w_cls = CLS_S;
            w_blk = {r_txd[63:40], 4'h0, w_code[3:0], 8'h33, 2'b01};
        end else if (w_t) begin
            w_cls = CLS_T;
            w_blk = {w_tpay, w_ttype, 2'b01};
        end else if (w_call) begin
            w_cls = CLS_C;
            w_blk = {w_code, 8'h1E, 2'b01};
        end else if (w_os) begin
            w_cls = CLS_C;
            w_blk = {w_code[7:4], 4'h0, r_txd[31:8], 8'h4B, 2'b01};
        end
    end

    function automatic tx_state_t f_next(input tx_state_t st, input blk_cls_t c);
        tx_state_t n;
        n = TX_E;
        case (st)
            TX_D:    n = (c == CLS_D) ? TX_D : (c == CLS_T) ? TX_T : TX_E;
            TX_E:    n = (c == CLS_D || c == CLS_S) ? TX_D :
                         (c == CLS_C) ? TX_C : (c == CLS_T) ? TX_T : TX_E;
            default: n = (c == CLS_C) ? TX_C : (c == CLS_S) ? TX_D : TX_E;
        endcase
        return n;
    endfunction

    assign w_nxt = f_next(r_state, w_cls);

    // Stage 2: state machine with registered block and class outputs
    always_ff @(posedge clk156) begin
        if (rst156) begin
            r_state     <= TX_INIT;
            TXD_Encoded <= LBLOCK_T;
            tx_type     <= 3'd0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt == TX_E) begin
                TXD_Encoded <= EBLOCK_T;
                tx_type     <= 3'd4;
            end else begin
                TXD_Encoded <= w_blk;
                tx_type     <= w_cls;
            end
        end
    end

`ifdef ENC_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_errcnt;

    // Clear beats a simultaneous increment
    always_ff @(posedge clk156) begin
        if (rst156 || clear_errblk)
            r_errcnt <= '0;
        else if (w_nxt == TX_E && r_errcnt != '1)
            r_errcnt <= r_errcnt + 1'b1;
    end

    assign errd_blks = r_errcnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = clear_errblk;
    assign errd_blks    = '0;
`endif

endmodule
